// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared widths, FSM encoding and tag-entry helpers for the
//               2-way read-only cache refill controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int INDEX_W   = 9;
    localparam int TAG_W     = 17;
    localparam int WORD_W    = 4;
    localparam int ENTRY_W   = 18;
    localparam int VALID_BIT = 17;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_REFILL = 3'd2,
        ST_TAG_WR = 3'd3,
        ST_RETRY  = 3'd4,
        ST_INV    = 3'd5
    } state_t;

    // Way A lives in the upper half of the tag word, way B in the lower half.
    function automatic logic [ENTRY_W-1:0] way_a_half(input logic [2*ENTRY_W-1:0] word);
        return word[2*ENTRY_W-1:ENTRY_W];
    endfunction

    function automatic logic [ENTRY_W-1:0] way_b_half(input logic [2*ENTRY_W-1:0] word);
        return word[ENTRY_W-1:0];
    endfunction

    function automatic logic [ENTRY_W-1:0] make_entry(input logic [TAG_W-1:0] tag);
        return {1'b1, tag};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_way_select.sv
`default_nettype none
// ============================================================================
// Module      : cache_way_select
// Description : Combinational hit detection and victim choice for one set.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_way_select
    import cache_pkg::*;
(
    input  logic [ENTRY_W-1:0] entry_a,
    input  logic [ENTRY_W-1:0] entry_b,
    input  logic [TAG_W-1:0]   tag,
    input  logic               lru_flag,
    output logic [1:0]         hit,
    output logic [1:0]         victim
);

    logic w_valid_a;
    logic w_valid_b;

    assign w_valid_a = entry_a[VALID_BIT];
    assign w_valid_b = entry_b[VALID_BIT];

    assign hit[1] = w_valid_a && (entry_a[TAG_W-1:0] == tag);
    assign hit[0] = w_valid_b && (entry_b[TAG_W-1:0] == tag);

    // Empty ways are filled before anything is evicted, B first.
    always_comb begin
        victim = 2'b00;
        if (!w_valid_b) begin
            victim = 2'b01;
        end else if (!w_valid_a) begin
            victim = 2'b10;
        end else begin
            victim = lru_flag ? 2'b10 : 2'b01;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_refill_ctrl
// Description : Hit detection, LRU update, line refill and invalidate control
//               for a 2-way, 512-set read-only cache.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int LINE_WORDS = 16,
    parameter int ADDR_W     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cpu_req,
    input  logic [ADDR_W-1:0]          cpu_addr,
    output logic                       cpu_ack,
    output logic [31:0]                cpu_rdata,
    input  logic                       inv_req,
    input  logic [INDEX_W-1:0]         inv_index,
    output logic                       inv_ack,
    output logic [1:0]                 tag_we,
    output logic [INDEX_W-1:0]         tag_addr,
    output logic [2*ENTRY_W-1:0]       tag_din,
    input  logic [2*ENTRY_W-1:0]       tag_dout,
    output logic                       lru_req,
    output logic [INDEX_W-1:0]         lru_addr,
    output logic [1:0]                 lru_hit,
    input  logic                       lru_flag,
    output logic [1:0]                 data_we,
    output logic [INDEX_W+WORD_W-1:0]  data_addr,
    output logic [31:0]                data_din,
    input  logic [63:0]                data_dout,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic                       mem_valid,
    input  logic [31:0]                mem_rdata
);

    localparam int c_WORD_LSB  = 2;
    localparam int c_INDEX_LSB = 6;
    localparam int c_TAG_LSB   = 15;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:2]   r_addr;
    logic [1:0]          r_victim;
    logic [WORD_W-1:0]   r_beat;

    logic [TAG_W-1:0]    w_tag;
    logic [INDEX_W-1:0]  w_index;
    logic [WORD_W-1:0]   w_word;
    logic [INDEX_W-1:0]  w_cpu_index;
    logic [WORD_W-1:0]   w_cpu_word;
    logic [1:0]          w_hit;
    logic [1:0]          w_victim;
    logic                w_last_beat;
    logic                w_start;
    logic [ENTRY_W-1:0]  w_new_entry;
    logic                w_unused_addr_lsbs;

    assign w_tag       = r_addr[c_TAG_LSB +: TAG_W];
    assign w_index     = r_addr[c_INDEX_LSB +: INDEX_W];
    assign w_word      = r_addr[c_WORD_LSB +: WORD_W];
    assign w_cpu_index = cpu_addr[c_INDEX_LSB +: INDEX_W];
    assign w_cpu_word  = cpu_addr[c_WORD_LSB +: WORD_W];
    assign w_last_beat = (r_beat == WORD_W'(LINE_WORDS - 1));
    assign w_start     = (r_state == ST_IDLE) && !inv_req && cpu_req;
    assign w_new_entry = make_entry(w_tag);

    assign w_unused_addr_lsbs = ^cpu_addr[1:0];

    cache_way_select u_way_select (
        .entry_a  (way_a_half(tag_dout)),
        .entry_b  (way_b_half(tag_dout)),
        .tag      (w_tag),
        .lru_flag (lru_flag),
        .hit      (w_hit),
        .victim   (w_victim)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_victim <= '0;
            r_beat   <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_addr <= cpu_addr[ADDR_W-1:2];
            end
            if ((r_state == ST_LOOKUP) && (w_hit == 2'b00)) begin
                r_victim <= w_victim;
            end
            if ((r_state == ST_REFILL) && mem_valid) begin
                r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        cpu_ack   = 1'b0;
        cpu_rdata = '0;
        inv_ack   = 1'b0;
        tag_we    = 2'b00;
        tag_addr  = '0;
        tag_din   = '0;
        lru_req   = 1'b0;
        lru_addr  = '0;
        lru_hit   = 2'b00;
        data_we   = 2'b00;
        data_addr = '0;
        data_din  = '0;
        mem_req   = 1'b0;
        mem_addr  = '0;

        case (r_state)
            ST_IDLE: begin
                if (inv_req) begin
                    w_next = ST_INV;
                end else if (cpu_req) begin
                    tag_addr  = w_cpu_index;
                    data_addr = {w_cpu_index, w_cpu_word};
                    w_next    = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                lru_addr = w_index;
                if (w_hit != 2'b00) begin
                    cpu_ack   = 1'b1;
                    cpu_rdata = w_hit[1] ? data_dout[63:32] : data_dout[31:0];
                    // A double hit means corrupt tags; leave the LRU alone.
                    lru_req   = (w_hit != 2'b11);
                    lru_hit   = w_hit;
                    w_next    = ST_IDLE;
                end else begin
                    w_next = ST_REFILL;
                end
            end
            ST_REFILL: begin
                mem_req   = 1'b1;
                mem_addr  = {r_addr[ADDR_W-1:c_INDEX_LSB], 6'b0};
                data_addr = {w_index, r_beat};
                if (mem_valid) begin
                    data_we  = r_victim;
                    data_din = mem_rdata;
                    if (w_last_beat) begin
                        w_next = ST_TAG_WR;
                    end
                end
            end
            ST_TAG_WR: begin
                tag_we   = r_victim;
                tag_addr = w_index;
                tag_din  = {r_victim[1] ? w_new_entry : '0,
                            r_victim[0] ? w_new_entry : '0};
                lru_req  = 1'b1;
                lru_addr = w_index;
                lru_hit  = r_victim;
                w_next   = ST_RETRY;
            end
            ST_RETRY: begin
                tag_addr  = w_index;
                data_addr = {w_index, w_word};
                w_next    = ST_LOOKUP;
            end
            ST_INV: begin
                tag_we   = 2'b11;
                tag_addr = inv_index;
                inv_ack  = 1'b1;
                w_next   = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
